// File: rtl/prog_clock_div.sv
// Multi-channel programmable clock divider with per-channel tick and registered square wave.
// Optional phase-align input sync_i is present only when CLKDIV_SYNC_EN is defined.
module prog_clock_div #(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned DEFAULT_DIV = 4,
   localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clock_in_i,
   input  logic              reset_i,
`ifdef CLKDIV_SYNC_EN
   input  logic              sync_i,
`endif
   input  logic [NUM_CH-1:0] en_i,
   input  logic [CNT_W-1:0]  div_i,
   input  logic [CH_W-1:0]   div_ch_i,
   input  logic              div_load_i,
   output logic [NUM_CH-1:0] div_busy_o,
   output logic [NUM_CH-1:0] tick_o,
   output logic [NUM_CH-1:0] clock_out_o
);

   logic              sync;
   logic [CNT_W-1:0]  cnt_q  [NUM_CH];
   logic [CNT_W-1:0]  cnt_d  [NUM_CH];
   logic [CNT_W-1:0]  div_q  [NUM_CH];
   logic [CNT_W-1:0]  div_d  [NUM_CH];
   logic [CNT_W-1:0]  pend_q [NUM_CH];
   logic [CNT_W-1:0]  pend_d [NUM_CH];
   logic [CNT_W:0]    high   [NUM_CH];
   logic [NUM_CH-1:0] wrap;
   logic [NUM_CH-1:0] busy_q, busy_d;
   logic [NUM_CH-1:0] tick_q, tick_d;
   logic [NUM_CH-1:0] clk_q, clk_d;
   logic [CNT_W-1:0]  div_eff;

`ifdef CLKDIV_SYNC_EN
   assign sync = sync_i;
`else
   assign sync = 1'b0;
`endif

   // Divisors below 2 cannot make a square wave, so they are clamped before storage.
   assign div_eff = (div_i < CNT_W'(2)) ? CNT_W'(2) : div_i;

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         cnt_d[i]  = cnt_q[i];
         div_d[i]  = div_q[i];
         pend_d[i] = pend_q[i];
         busy_d[i] = busy_q[i];
         tick_d[i] = 1'b0;
         clk_d[i]  = 1'b0;
         // Extra bit keeps the all-ones divisor from overflowing.
         high[i]   = ({1'b0, div_q[i]} + (CNT_W+1)'(1)) >> 1;
         wrap[i]   = en_i[i] && (sync || (cnt_q[i] == div_q[i] - CNT_W'(1)));

         if (en_i[i]) begin
            cnt_d[i]  = wrap[i] ? '0 : cnt_q[i] + CNT_W'(1);
            tick_d[i] = wrap[i];
            clk_d[i]  = ({1'b0, cnt_d[i]} < high[i]);
            if (wrap[i] && busy_q[i]) begin
               div_d[i]  = pend_q[i];
               busy_d[i] = 1'b0;
            end
         end else begin
            cnt_d[i] = div_q[i] - CNT_W'(1);
            if (busy_q[i]) begin
               div_d[i]  = pend_q[i];
               cnt_d[i]  = pend_q[i] - CNT_W'(1);
               busy_d[i] = 1'b0;
            end
         end

         // A load on the applying edge re-arms pending for the following wrap.
         if (div_load_i && (div_ch_i == CH_W'(i))) begin
            pend_d[i] = div_eff;
            busy_d[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clock_in_i) begin
      if (reset_i) begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i]  <= CNT_W'(DEFAULT_DIV) - CNT_W'(1);
            div_q[i]  <= CNT_W'(DEFAULT_DIV);
            pend_q[i] <= CNT_W'(DEFAULT_DIV);
         end
         busy_q <= '0;
         tick_q <= '0;
         clk_q  <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i]  <= cnt_d[i];
            div_q[i]  <= div_d[i];
            pend_q[i] <= pend_d[i];
         end
         busy_q <= busy_d;
         tick_q <= tick_d;
         clk_q  <= clk_d;
      end
   end

   assign div_busy_o  = busy_q;
   assign tick_o      = tick_q;
   assign clock_out_o = clk_q;

endmodule

// File: tb/tb_prog_clock_div.sv
// Scoreboard bench for prog_clock_div: directed stimulus pushes hand-derived expectations,
// a negedge monitor pops and compares them. Define CLKDIV_SYNC_EN to exercise sync_i.
module tb_prog_clock_div;

   localparam int unsigned CNT_W = 16;

   typedef struct {
      int         cyc;
      logic [3:0] tick;
      logic [3:0] clk;
      logic [3:0] busy;
      logic [2:0] busy3;
      string      name;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        sync;
   logic [3:0]  en;
   logic [CNT_W-1:0] div;
   logic [1:0]  div_ch;
   logic        load;
   logic [3:0]  busy, tick, cout;
   logic [1:0]  div_ch3;
   logic        load3;
   logic [2:0]  busy3, tick3, cout3;

   int   ecnt = 0;
   int   n_vec = 0;
   int   n_bad = 0;
   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) ecnt <= ecnt + 1;

   prog_clock_div #(.NUM_CH(4), .CNT_W(CNT_W), .DEFAULT_DIV(4)) u_dut (
      .clock_in_i  (clk),
      .reset_i     (reset),
`ifdef CLKDIV_SYNC_EN
      .sync_i      (sync),
`endif
      .en_i        (en),
      .div_i       (div),
      .div_ch_i    (div_ch),
      .div_load_i  (load),
      .div_busy_o  (busy),
      .tick_o      (tick),
      .clock_out_o (cout)
   );

   // Three channels leave div_ch_i == 3 unmapped, so that load must be dropped.
   prog_clock_div #(.NUM_CH(3), .CNT_W(CNT_W), .DEFAULT_DIV(4)) u_dut3 (
      .clock_in_i  (clk),
      .reset_i     (reset),
`ifdef CLKDIV_SYNC_EN
      .sync_i      (1'b0),
`endif
      .en_i        (3'h7),
      .div_i       (div),
      .div_ch_i    (div_ch3),
      .div_load_i  (load3),
      .div_busy_o  (busy3),
      .tick_o      (tick3),
      .clock_out_o (cout3)
   );

   function automatic void pat(input int c, input int s, input int d,
                               output logic t, output logic k);
      t = (c >= s) && (((c - s) % d) == 0);
      k = (c >= s) && (((c - s) % d) < (d + 1) / 2);
   endfunction

   // Hand-derived schedule: each channel's waveform restarts at (start, divisor) per segment.
   function automatic exp_t exp_at(input int c, input bit sync_on);
      exp_t e;
      int s, d;
      bit z;
      e.cyc = 0; e.busy3 = '0; e.name = $sformatf("cycle%0d", c);
      for (int ch = 0; ch < 4; ch++) begin
         z = 0; s = 1; d = 4;
         if (c == 30) z = 1;
         else if (ch == 0) begin
            if (sync_on && c >= 45)  begin s = 45; d = 3; end
            else if (c >= 43)        begin s = 43; d = 3; end
            else if (c >= 31)        begin s = 31; d = 4; end
            else if (c >= 25)        begin s = 25; d = 9; end
         end else begin
            if (sync_on && c >= 45)  begin s = 45; d = 4; end
            else if (c >= 31)        begin s = 31; d = 4; end
            else if (ch == 1 && c >= 13) begin s = 13; d = 5; end
            else if (ch == 2 && c >= 13) begin s = 13; d = 2; end
            else if (ch == 3 && c >= 21) begin s = 21; d = 4; end
            else if (ch == 3 && c >= 18) z = 1;
         end
         if (z) begin e.tick[ch] = 1'b0; e.clk[ch] = 1'b0; end
         else pat(c, s, d, e.tick[ch], e.clk[ch]);
      end
      e.busy[0] = (c == 23) || (c == 24) || (c >= 39 && c <= 42);
      e.busy[1] = (c >= 10 && c <= 12);
      e.busy[2] = (c == 11) || (c == 12) || (c == 16);
      e.busy[3] = 1'b0;
      return e;
   endfunction

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= ecnt) begin
         exp_t e;
         e = sb.pop_front();
         n_vec++;
         if (e.cyc != ecnt) begin
            n_bad++;
            $display("FAIL %s: expectation for edge %0d missed, now at edge %0d", e.name, e.cyc,
                     ecnt);
         end else if (tick !== e.tick || cout !== e.clk || busy !== e.busy || busy3 !== e.busy3)
         begin
            n_bad++;
            $display("FAIL %s: tick=%b clk=%b busy=%b busy3=%b, expected tick=%b clk=%b busy=%b busy3=%b",
                     e.name, tick, cout, busy, busy3, e.tick, e.clk, e.busy, e.busy3);
         end
      end
   end

   task automatic load_main(input logic [1:0] ch, input int unsigned v);
      load = 1'b1; div_ch = ch; div = CNT_W'(v);
   endtask

   initial begin
      exp_t e;
      int   base;
      bit   sync_on;
`ifdef CLKDIV_SYNC_EN
      sync_on = 1;
`else
      sync_on = 0;
`endif
      reset = 1'b1; sync = 1'b0; en = 4'h0; div = '0; div_ch = '0; load = 1'b0;
      div_ch3 = '0; load3 = 1'b0;
      @(posedge clk); #1;
      for (int r = 0; r < 2; r++) begin
         e = '{cyc: ecnt + 1, tick: 4'h0, clk: 4'h0, busy: 4'h0, busy3: 3'h0,
               name: $sformatf("reset%0d", r)};
         sb.push_back(e);
         @(posedge clk); #1;
      end
      base = ecnt;
      for (int c = 1; c <= 50; c++) begin
         reset = 1'b0; en = 4'hF; load = 1'b0; load3 = 1'b0; sync = 1'b0;
         case (c)
            10: load_main(2'd1, 5);
            11: load_main(2'd2, 0);
            16: load_main(2'd2, 1);
            18, 19, 20: en = 4'h7;
            22: begin load3 = 1'b1; div_ch3 = 2'd3; div = CNT_W'(7); end
            23: load_main(2'd0, 7);
            24: load_main(2'd0, 9);
            30: begin reset = 1'b1; load_main(2'd1, 6); end
            39: load_main(2'd0, 3);
            45: sync = sync_on;
            default: ;
         endcase
         e = exp_at(c, sync_on);
         e.cyc = base + c;
         sb.push_back(e);
         @(posedge clk); #1;
      end
      load = 1'b0; sync = 1'b0;
      for (int w = 0; w < 5 && sb.size() > 0; w++) @(posedge clk);
      if (sb.size() > 0) begin
         n_bad++;
         $display("FAIL drain: %0d expectations never checked, expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
